// File: rtl/bird_renderer.sv
// bird_renderer: pixel stage behind VGA_timings. It holds the SpacyBird game FSM and the
// per-frame gravity/flap physics, and it outputs registered 12-bit RGB plus sync delayed by
// one cycle. Optional build macro: BIRD_BORDER_EN draws a 1-pixel white frame on the
// visible area.
module bird_renderer #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter int unsigned H_TOT     = 800,
  parameter int unsigned V_TOT     = 525,
  parameter int unsigned BIRD_X    = 100,
  parameter int unsigned BIRD_SIZE = 16,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned FLAP_VEL  = 8,
  parameter int unsigned MAX_FALL  = 12
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iHS,
  input  logic                     iVS,
  input  logic [$clog2(H_TOT)-1:0] iH,
  input  logic [$clog2(V_TOT)-1:0] iV,
  input  logic                     iActive,
  input  logic                     iFlap,
  output logic                     oHS,
  output logic                     oVS,
  output logic [3:0]               oRed,
  output logic [3:0]               oGreen,
  output logic [3:0]               oBlue,
  output logic                     oDead
);

  localparam int unsigned HW = $clog2(H_TOT);
  localparam int unsigned VW = $clog2(V_TOT);
  localparam int unsigned YW = $clog2(HEIGHT);

  localparam logic [YW-1:0] YStart  = YW'(HEIGHT / 2 - BIRD_SIZE / 2);
  localparam logic [YW-1:0] YFloor  = YW'(HEIGHT - BIRD_SIZE);
  localparam logic [5:0]    VelFlap = 6'(0) - 6'(FLAP_VEL);

  typedef enum logic [1:0] {StReady, StFlying, StDead} state_e;

  state_e          state_q;
  logic [YW-1:0]   y_q;
  logic [5:0]      vel_q;      // two's complement, positive = downward
  logic            dead_q;
  logic            flap_q, flap_prev_q;
  logic            flap_pend_q, flap_pend_d;
  logic            tick;
  logic [6:0]      vel_inc;
  logic [5:0]      vel_n;
  logic [10:0]     ny;
  logic            ny_neg, ny_floor;
  logic            in_x, in_y;
  logic [11:0]     rgb_d, rgb_q;
  logic            hs_q, vs_q;

  // Frame tick lands in vertical blanking, so physics never tears a visible frame.
  assign tick = (iV == VW'(HEIGHT)) && (iH == '0);

  // Flap pending: edges are detected on the registered button; the tick clear wins.
  always_comb begin
    flap_pend_d = flap_pend_q | (flap_q & ~flap_prev_q);
    if (tick) flap_pend_d = 1'b0;
  end

  // Flap button registers and pending flag.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      flap_q      <= 1'b0;
      flap_prev_q <= 1'b0;
      flap_pend_q <= 1'b0;
    end else begin
      flap_q      <= iFlap;
      flap_prev_q <= flap_q;
      flap_pend_q <= flap_pend_d;
    end
  end

  // Candidate physics step: new velocity and position at 11-bit signed width.
  always_comb begin
    vel_inc = {vel_q[5], vel_q} + 7'(GRAVITY);
    if (flap_pend_q) begin
      vel_n = VelFlap;
    end else if ($signed(vel_inc) > $signed(7'(MAX_FALL))) begin
      vel_n = 6'(MAX_FALL);
    end else begin
      vel_n = vel_inc[5:0];
    end
    ny       = 11'(y_q) + {{5{vel_n[5]}}, vel_n};
    ny_neg   = ny[10];
    ny_floor = !ny[10] && (ny >= 11'(HEIGHT - BIRD_SIZE));
  end

  // Game FSM and bird state, advanced only on frame ticks.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= StReady;
      y_q     <= YStart;
      vel_q   <= '0;
      dead_q  <= 1'b0;
    end else if (tick) begin
      unique case (state_q)
        StReady, StFlying: begin
          if (state_q == StFlying || flap_pend_q) begin
            if (ny_neg) begin
              y_q     <= '0;
              vel_q   <= '0;
              state_q <= StFlying;
            end else if (ny_floor) begin
              y_q     <= YFloor;
              vel_q   <= '0;
              state_q <= StDead;
              dead_q  <= 1'b1;
            end else begin
              y_q     <= ny[YW-1:0];
              vel_q   <= vel_n;
              state_q <= StFlying;
            end
          end
        end
        StDead: begin
          if (flap_pend_q) begin
            state_q <= StReady;
            y_q     <= YStart;
            vel_q   <= '0;
            dead_q  <= 1'b0;
          end
        end
        default: state_q <= StReady;
      endcase
    end
  end

  // Pixel colour from the incoming counters and current bird state.
  always_comb begin
    in_x  = (iH >= HW'(BIRD_X)) && (iH < HW'(BIRD_X + BIRD_SIZE)) && (iH < HW'(WIDTH));
    in_y  = (11'(iV) >= 11'(y_q)) && (11'(iV) < 11'(y_q) + 11'(BIRD_SIZE));
    rgb_d = 12'h000;
    if (iActive) begin
      if (in_x && in_y) begin
        rgb_d = (state_q == StDead) ? 12'hF00 : 12'hFF0;
      end else begin
        rgb_d = 12'h4AF;
      end
`ifdef BIRD_BORDER_EN
      if (iH == '0 || iH == HW'(WIDTH - 1) || iV == '0 || iV == VW'(HEIGHT - 1)) begin
        rgb_d = 12'hFFF;
      end
`else
`endif
    end
  end

  // Output registers keep RGB and sync mutually aligned one cycle behind the inputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      rgb_q <= 12'h000;
    end else begin
      hs_q  <= iHS;
      vs_q  <= iVS;
      rgb_q <= rgb_d;
    end
  end

  assign oHS    = hs_q;
  assign oVS    = vs_q;
  assign oRed   = rgb_q[11:8];
  assign oGreen = rgb_q[7:4];
  assign oBlue  = rgb_q[3:0];
  assign oDead  = dead_q;

endmodule

// File: tb/tb_bird_renderer.sv
// Directed bench for bird_renderer: counters are driven directly (no full frame scans), and
// frame ticks are produced by presenting iV == 480, iH == 0 for one cycle.
module tb_bird_renderer;

  logic       iClk = 1'b0;
  logic       iRst, iHS, iVS, iActive, iFlap;
  logic [9:0] iH, iV;
  logic       oHS, oVS, oDead;
  logic [3:0] oRed, oGreen, oBlue;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  bird_renderer dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iHS    (iHS),
    .iVS    (iVS),
    .iH     (iH),
    .iV     (iV),
    .iActive(iActive),
    .iFlap  (iFlap),
    .oHS    (oHS),
    .oVS    (oVS),
    .oRed   (oRed),
    .oGreen (oGreen),
    .oBlue  (oBlue),
    .oDead  (oDead)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic px(input int h, input int v, input logic [11:0] exp, input string tag);
    iH      = 10'(h);
    iV      = 10'(v);
    iActive = 1'b1;
    step();
    check(tag, {20'd0, oRed, oGreen, oBlue}, {20'd0, exp});
    iActive = 1'b0;
  endtask

  task automatic tick();
    iV      = 10'd480;
    iH      = 10'd0;
    iActive = 1'b0;
    step();
    iH = 10'd1;
    step();
    iV = 10'd10;
  endtask

  task automatic flap();
    iFlap = 1'b1;
    step();
    step();
    iFlap = 1'b0;
    step();
    step();
  endtask

  // Checks top edge, bottom row and the sky just outside the bird at column BIRD_X.
  task automatic bird_at(input int y, input logic [11:0] col, input string tag);
    px(100, y, col, $sformatf("%s_top%0d", tag, y));
    if (y > 0) px(100, y - 1, 12'h4AF, $sformatf("%s_above", tag));
    px(100, y + 15, col, $sformatf("%s_bottom", tag));
    if (y + 16 < 480) px(100, y + 16, 12'h4AF, $sformatf("%s_below", tag));
  endtask

  initial begin
    iRst = 1'b1; iHS = 1'b1; iVS = 1'b1; iActive = 1'b1; iFlap = 1'b0;
    iH = 10'd100; iV = 10'd232;
    step();
    step();
    check("rst_hs", {31'd0, oHS}, 32'd0);
    check("rst_vs", {31'd0, oVS}, 32'd0);
    check("rst_rgb", {20'd0, oRed, oGreen, oBlue}, 32'h000);
    check("rst_dead", {31'd0, oDead}, 32'd0);

    iRst = 1'b0; iHS = 1'b0; iVS = 1'b0; iActive = 1'b0;
    px(100, 232, 12'hFF0, "ready_tl");
    px(115, 247, 12'hFF0, "ready_br");
    px(99, 232, 12'h4AF, "left_of_bird");
    px(116, 232, 12'h4AF, "right_of_bird");
    px(0, 0, 12'h4AF, "sky_00");
    iH = 10'd700; iV = 10'd10; iActive = 1'b0;
    step();
    check("blank_rgb", {20'd0, oRed, oGreen, oBlue}, 32'h000);
    iHS = 1'b1; iVS = 1'b0;
    step();
    check("hs_delay_hi", {31'd0, oHS}, 32'd1);
    check("vs_delay_lo", {31'd0, oVS}, 32'd0);
    iHS = 1'b0; iVS = 1'b1;
    step();
    check("hs_delay_lo", {31'd0, oHS}, 32'd0);
    check("vs_delay_hi", {31'd0, oVS}, 32'd1);
    iVS = 1'b0;

    // Two idle frames: bird stays parked.
    tick();
    tick();
    check("idle_dead", {31'd0, oDead}, 32'd0);
    bird_at(232, 12'hFF0, "idle");

    // Two flap edges in one frame count as a single flap.
    flap();
    flap();
    tick();
    bird_at(224, 12'hFF0, "flap_t0");
    check("flap_t0_dead", {31'd0, oDead}, 32'd0);
    tick();
    bird_at(217, 12'hFF0, "fall_t1");

    // Free fall: velocity climbs to 12 and saturates, then the floor kills the bird.
    for (int t = 2; t <= 36; t++) begin
      tick();
      case (t)
        8:  bird_at(196, 12'hFF0, "apex_t8");
        20: bird_at(274, 12'hFF0, "fall_t20");
        21: bird_at(286, 12'hFF0, "sat_t21");
        35: begin
          bird_at(454, 12'hFF0, "fall_t35");
          check("alive_t35", {31'd0, oDead}, 32'd0);
        end
        default: ;
      endcase
    end
    check("floor_dead", {31'd0, oDead}, 32'd1);
    bird_at(464, 12'hF00, "floor");
    tick();
    check("dead_hold", {31'd0, oDead}, 32'd1);

    // Respawn.
    flap();
    tick();
    check("respawn_dead", {31'd0, oDead}, 32'd0);
    bird_at(232, 12'hFF0, "respawn");

    // Climb to y = 5 then hit the ceiling.
    flap();
    tick();
    for (int t = 1; t <= 6; t++) tick();
    bird_at(197, 12'hFF0, "pre_climb");
    for (int k = 1; k <= 24; k++) begin
      flap();
      tick();
    end
    bird_at(5, 12'hFF0, "y5");
    flap();
    tick();
    bird_at(0, 12'hFF0, "ceil1");
    flap();
    tick();
    bird_at(0, 12'hFF0, "ceil2");
    tick();
    bird_at(1, 12'hFF0, "ceil_vel0");
    check("ceil_dead", {31'd0, oDead}, 32'd0);

    // Reset mid-line while flying.
    iH = 10'd100; iV = 10'd1; iActive = 1'b1; iHS = 1'b1; iRst = 1'b1;
    step();
    check("midrst_rgb", {20'd0, oRed, oGreen, oBlue}, 32'h000);
    check("midrst_hs", {31'd0, oHS}, 32'd0);
    iRst = 1'b0; iHS = 1'b0; iActive = 1'b0;
    px(100, 232, 12'hFF0, "midrst_bird");
    px(100, 1, 12'h4AF, "midrst_old_y");
    tick();
    px(100, 232, 12'hFF0, "midrst_ready_hold");

`ifdef BIRD_BORDER_EN
    px(0, 10, 12'hFFF, "border_left");
    px(639, 10, 12'hFFF, "border_right");
    px(10, 479, 12'hFFF, "border_bottom");
    px(1, 1, 12'h4AF, "border_inner");
`else
    px(0, 10, 12'h4AF, "noborder_left");
    px(639, 10, 12'h4AF, "noborder_right");
    px(10, 479, 12'h4AF, "noborder_bottom");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bird_renderer.md
# bird_renderer

Pixel-generation stage fed directly by `VGA_timings`: consumes its sync pulses, H/V counters and active flag, and produces registered 12-bit RGB plus re-aligned sync for the VGA connector. Holds the SpacyBird bird state: a 3-state game FSM and per-frame gravity/flap physics updated once per frame during vertical blanking. Draws a square bird on a sky background.

## Interface
Parameters:
- `WIDTH`, 640, visible pixels per line
- `HEIGHT`, 480, visible lines per frame
- `H_TOT`, 800, total clocks per line; sets `iH` width `$clog2(H_TOT)`
- `V_TOT`, 525, total lines per frame; sets `iV` width `$clog2(V_TOT)`
- `BIRD_X`, 100, left column of the bird
- `BIRD_SIZE`, 16, bird edge length in pixels
- `GRAVITY`, 1, velocity increment per frame
- `FLAP_VEL`, 8, upward speed set by a flap; must be ≤ 31
- `MAX_FALL`, 12, downward speed clamp; must be ≤ 31

Ports:
- `iClk` in 1: pixel clock
- `iRst` in 1: synchronous, active-high reset
- `iHS`, `iVS` in 1 each: sync from `VGA_timings`
- `iH` in `$clog2(H_TOT)`: horizontal counter
- `iV` in `$clog2(V_TOT)`: vertical counter
- `iActive` in 1: visible-area flag
- `iFlap` in 1: flap button, already synchronous to `iClk`
- `oHS`, `oVS` out 1 each: sync delayed to match RGB
- `oRed`, `oGreen`, `oBlue` out 4 each: pixel colour
- `oDead` out 1: high while the FSM is in DEAD

## Operation
- Frame tick: one-cycle pulse when `iV == HEIGHT && iH == 0`. It falls in vertical blanking, so no mid-frame tearing.
- Flap edge: `iFlap` is registered. A rising edge sets `flap_pend`. `flap_pend` clears only on a frame tick. Multiple edges within one frame count as one.
- State `y`: unsigned, `$clog2(HEIGHT)` bits.
- State `vel`: signed, 6 bits; positive means downward.
- FSM states:
  - READY: `y = HEIGHT/2 - BIRD_SIZE/2`, `vel = 0`. On a tick with `flap_pend`, go to FLYING and apply the flap update the same tick.
  - FLYING: on each tick, `vel_n = flap_pend ? -FLAP_VEL : min(vel + GRAVITY, MAX_FALL)`; `ny = y + vel_n`, computed at 11-bit signed width.
    - If `ny < 0`: `y = 0`, `vel = 0`.
    - If `ny ≥ HEIGHT - BIRD_SIZE`: `y = HEIGHT - BIRD_SIZE`, `vel = 0`, go to DEAD.
    - Otherwise: `y = ny`, `vel = vel_n`.
  - DEAD: bird frozen. On a tick with `flap_pend`, go to READY and reload the READY values.
- Pixel colour:
  - `iActive == 0`: `000`.
  - Bird hit (`BIRD_X ≤ iH < BIRD_X + BIRD_SIZE` and `y ≤ iV < y + BIRD_SIZE`): `FF0` (yellow) in READY/FLYING, `F00` in DEAD.
  - Otherwise: sky `4AF`.

## Timing
- Reset values: `oHS = 0`, `oVS = 0`, RGB `000`, `oDead = 0`, FSM READY, `y = HEIGHT/2 - BIRD_SIZE/2`, `vel = 0`, `flap_pend = 0`, flap register 0.
- RGB, `oHS`, `oVS` are registered with 1-cycle latency from `iH`/`iV`/`iActive`/`iHS`/`iVS`, so all outputs stay mutually aligned.
- `y`, `vel`, FSM and `oDead` change only on the clock edge ending a tick cycle. `oDead` is registered from the state.
- A flap edge in the tick cycle itself is seen at the next tick; `flap_pend` clear takes priority over a same-cycle set.
- A reset asserted mid-frame takes effect on the next edge. Output after reset release follows the incoming counters one cycle later; no frame resync is needed.

## Configuration
- `BIRD_BORDER_EN` defined: active pixels with `iH == 0`, `iH == WIDTH-1`, `iV == 0` or `iV == HEIGHT-1` are white `FFF`, overriding the bird and sky.
- `BIRD_BORDER_EN` undefined: no border; the colour rules above apply unchanged. Latency is identical in both cases.

## Test plan
- Reset, then drive `VGA_timings` with defaults for 2 frames, no flap → `oDead = 0`. Pixel (`BIRD_X`, 232) is `FF0` one cycle after its counters; (0,0) is `4AF`; blanking is `000`; `oHS`/`oVS` equal inputs delayed by 1.
- Single flap pulse mid-frame 0 → at tick 0, FLYING with `y = 224`, `vel = -8`. At tick 1, `vel = -7`, `y = 217`.
- FLYING, no flaps → `vel` saturates at 12. Bird reaches `y = 464`, state DEAD, `oDead = 1`, bird pixels `F00`.
- Repeated flaps every frame from `y = 5` → `y` clamps at 0, `vel = 0`, no wrap to a large value.
- DEAD, flap → at the next tick, READY: `y = 232`, `vel = 0`, `oDead = 0`. Assert `iRst` mid-line during FLYING → all reset values on the next edge.
- With `BIRD_BORDER_EN`: pixels (0,10), (639,10) and (10,479) are `FFF`; (1,1) is `4AF`.
